// File: rtl/unscript_pkg.sv
// Shared frame format for the unscripted command link (tx side and feedback receiver).
// Latency: n/a (constants, types and a pure function only).
// Backpressure: n/a.
package unscript_pkg;

    localparam logic [1:0] TAG_FEEDBACK = 2'b01;
    localparam logic [1:0] TAG_OP       = 2'b10;
    localparam logic [1:0] TAG_POLL     = 2'b11;

    localparam logic [2:0] OP_UP       = 3'd0;
    localparam logic [2:0] OP_DOWN     = 3'd1;
    localparam logic [2:0] OP_LEFT     = 3'd2;
    localparam logic [2:0] OP_RIGHT    = 3'd3;
    localparam logic [2:0] OP_GET      = 3'd4;
    localparam logic [2:0] OP_PUT      = 3'd5;
    localparam logic [2:0] OP_INTERACT = 3'd6;
    localparam logic [2:0] OP_THROW    = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    // One command byte: upper three bits are always zero.
    function automatic logic [7:0] build_frame(input logic [2:0] opcode, input logic [1:0] tag);
        return {3'b000, opcode, tag};
    endfunction

endpackage

// File: rtl/unscript_arbiter.sv
// Picks the next frame: lowest pending opcode first, status poll only when no opcode pends.
// Latency: purely combinational.
// Backpressure: none; caller decides when the grant is taken.
module unscript_arbiter
    import unscript_pkg::*;
(
    input  logic [7:0] pending,
    input  logic       poll_req,
    output logic       grant,
    output logic [2:0] opcode,
    output logic       is_poll
);

    // Scan from the top so the lowest set index is the last one written.
    always_comb begin
        grant   = 1'b0;
        opcode  = 3'b000;
        is_poll = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (pending[i]) begin
                grant  = 1'b1;
                opcode = 3'(i);
            end
        end
        if (!grant && poll_req) begin
            grant   = 1'b1;
            is_poll = 1'b1;
        end
    end

endmodule

// File: rtl/send_unscript_cmd.sv
// Turns operation button levels and idle timeouts into one-byte UART command frames.
// Latency: op_req rise sampled at edge N -> send_valid registered at edge N+2 when idle and enabled.
// Backpressure: frame and send_valid hold while tx_ready is low; new requests collect as pending bits.
module send_unscript_cmd
    import unscript_pkg::*;
#(
    parameter int REPEAT_CYCLES = 2_000_000,
    parameter int POLL_CYCLES   = 500_000,
    parameter int GAP_CYCLES    = 1_000,
    parameter int NUM_OPS       = 8
) (
    input  logic               uart_clk,
    input  logic               rst,
    input  logic [NUM_OPS-1:0] op_req,
    input  logic               enable,
    input  logic               tx_ready,
    output logic [7:0]         data_send,
    output logic               send_valid,
    output logic               busy,
    output logic [3:0]         cmd_leds
);

    localparam int RW = $clog2(REPEAT_CYCLES) + 1;
    localparam int PW = $clog2(POLL_CYCLES) + 1;
    localparam int GW = $clog2(GAP_CYCLES) + 1;
    localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYCLES - 1);
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

    state_t             state, state_nx;
    logic [NUM_OPS-1:0] pending, prev_req, rise, rep_set, clr;
    logic [RW-1:0]      rep_cnt;
    logic [PW-1:0]      poll_cnt;
    logic [GW-1:0]      gap_cnt;
    logic [2:0]         last_op, sel_op, arb_op;
    logic               last_vld, sel_poll, arb_poll, grant;
    logic               poll_req, take, accept, poll_inc;
    logic               rep_restart, rep_run, rep_hit;

    unscript_arbiter u_arb (
        .pending  (pending),
        .poll_req (poll_req),
        .grant    (grant),
        .opcode   (arb_op),
        .is_poll  (arb_poll)
    );

    assign rise     = op_req & ~prev_req;
    assign poll_req = (poll_cnt == POLL_LAST);
    assign take     = (state == ST_IDLE) && enable && grant;
    assign accept   = (state == ST_SEND) && send_valid && tx_ready;
    assign poll_inc = (state == ST_IDLE) && (pending == '0) && enable && !poll_req;
    assign busy     = (state != ST_IDLE);

    // The repeat timer follows the last sent opcode; a new opcode restarts it.
    assign rep_restart = accept && !sel_poll && (!last_vld || (sel_op != last_op));
    assign rep_run     = last_vld && op_req[last_op];
    assign rep_hit     = !rep_restart && rep_run && (rep_cnt == REP_LAST);
    assign rep_set     = rep_hit ? (NUM_OPS'(1) << last_op) : '0;
    assign clr         = ((state == ST_LOAD) && !sel_poll) ? (NUM_OPS'(1) << sel_op) : '0;

    // Next-state decision for the frame sequencer.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (take) state_nx = ST_LOAD;
            ST_LOAD: state_nx = ST_SEND;
            ST_SEND: if (accept) state_nx = ST_GAP;
            ST_GAP:  if (gap_cnt == GAP_LAST) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge uart_clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    // Edge capture and per-opcode pending flags; the LOAD clear beats a same-cycle set.
    always_ff @(posedge uart_clk) begin
        if (rst) begin
            prev_req <= '0;
            pending  <= '0;
        end else begin
            prev_req <= op_req;
            pending  <= (pending | rise | rep_set) & ~clr;
        end
    end

    // Winner latch, frame register, handshake and LED update.
    always_ff @(posedge uart_clk) begin
        if (rst) begin
            sel_op     <= 3'b000;
            sel_poll   <= 1'b0;
            data_send  <= 8'h00;
            send_valid <= 1'b0;
            cmd_leds   <= 4'b0000;
        end else begin
            if (take) begin
                sel_op   <= arb_op;
                sel_poll <= arb_poll;
            end
            if (state == ST_LOAD) begin
                data_send  <= build_frame(sel_op, sel_poll ? TAG_POLL : TAG_OP);
                send_valid <= 1'b1;
            end
            if (accept) begin
                send_valid <= 1'b0;
                cmd_leds   <= sel_poll ? 4'b0000 : {1'b1, sel_op};
            end
        end
    end

    // Poll idle timer, inter-frame gap timer and hold-repeat timer.
    always_ff @(posedge uart_clk) begin
        if (rst) begin
            poll_cnt <= '0;
            gap_cnt  <= '0;
            rep_cnt  <= '0;
            last_op  <= 3'b000;
            last_vld <= 1'b0;
        end else begin
            if (accept)        poll_cnt <= '0;
            else if (poll_inc) poll_cnt <= poll_cnt + 1'b1;

            if (accept)                gap_cnt <= '0;
            else if (state == ST_GAP)  gap_cnt <= gap_cnt + 1'b1;

            if (rep_restart) begin
                rep_cnt  <= '0;
                last_op  <= sel_op;
                last_vld <= 1'b1;
            end else if (rep_run) begin
                rep_cnt <= rep_hit ? '0 : rep_cnt + 1'b1;
            end else begin
                rep_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_send_unscript_cmd.sv
// Bench for send_unscript_cmd: directed scenarios plus a randomized run against a reference model.
// Latency: n/a.
// Backpressure: tx_ready is driven both in directed stalls and randomly.
module tb_send_unscript_cmd;

    localparam int REP  = 100;
    localparam int POLL = 300;
    localparam int GAP  = 20;

    logic       uart_clk = 1'b0;
    logic       rst, enable, tx_ready, send_valid, busy;
    logic [7:0] op_req, data_send;
    logic [3:0] cmd_leds;

    int cmp_cnt = 0;
    int bad_cnt = 0;

    always #5 uart_clk = ~uart_clk;

    send_unscript_cmd #(
        .REPEAT_CYCLES (REP),
        .POLL_CYCLES   (POLL),
        .GAP_CYCLES    (GAP),
        .NUM_OPS       (8)
    ) dut (
        .uart_clk   (uart_clk),
        .rst        (rst),
        .op_req     (op_req),
        .enable     (enable),
        .tx_ready   (tx_ready),
        .data_send  (data_send),
        .send_valid (send_valid),
        .busy       (busy),
        .cmd_leds   (cmd_leds)
    );

    // Reference state: what has been requested, what is in flight, what is waiting.
    bit [7:0] m_pend, m_prev, m_frame;
    bit [3:0] m_leds;
    bit [2:0] m_sel, m_last;
    bit       m_selpoll, m_lastv, m_loading, m_valid, chk_en;
    int       m_rep, m_poll, m_gap, cyc;

    logic [7:0] dlog[$];
    int         dcyc[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            bad_cnt++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic step(input int k);
        repeat (k) begin
            @(posedge uart_clk);
            #1;
        end
    endtask

    task automatic wait_valid(input int budget, output int n);
        n = 0;
        while (!send_valid && n < budget) begin
            step(1);
            n++;
        end
        check("wait_send_valid", 32'(send_valid), 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            step(1);
            n++;
        end
        check("wait_idle", 32'(busy), 32'd0);
    endtask

    function automatic int logat(input int i);
        if (i < dlog.size()) return int'(dlog[i]);
        return 32'hEE;
    endfunction

    function automatic int cycat(input int i);
        if (i < dcyc.size()) return dcyc[i];
        return 0;
    endfunction

    // Reference model: one clock of the protocol from the inputs sampled at this edge.
    always @(posedge uart_clk) begin : model
        bit       idle, acc, ld, give, pinc, restart;
        bit [7:0] rise, rep_set, clr;
        cyc++;
        if (rst) begin
            m_pend = 0; m_prev = 0; m_frame = 0; m_leds = 0; m_sel = 0; m_last = 0;
            m_selpoll = 0; m_lastv = 0; m_loading = 0; m_valid = 0;
            m_rep = 0; m_poll = 0; m_gap = 0;
        end else begin
            idle = !m_loading && !m_valid && (m_gap == 0);
            acc  = m_valid && tx_ready;
            ld   = m_loading;
            give = idle && enable && ((m_pend != 0) || (m_poll == POLL - 1));
            pinc = idle && enable && (m_pend == 0) && (m_poll != POLL - 1);
            rise = op_req & ~m_prev;
            m_prev = op_req;
            rep_set = 0;
            clr = 0;
            restart = acc && !m_selpoll && (!m_lastv || (m_sel != m_last));
            if (restart) begin
                m_rep = 0; m_last = m_sel; m_lastv = 1;
            end else if (m_lastv && op_req[m_last]) begin
                if (m_rep == REP - 1) begin
                    rep_set[m_last] = 1'b1;
                    m_rep = 0;
                end else begin
                    m_rep++;
                end
            end else begin
                m_rep = 0;
            end
            if (m_gap > 0) m_gap--;
            if (pinc) m_poll++;
            if (acc) begin
                m_valid = 0;
                m_leds  = m_selpoll ? 4'h0 : {1'b1, m_sel};
                m_poll  = 0;
                m_gap   = GAP;
                cyc     = cyc;
            end
            if (ld) begin
                m_loading = 0;
                m_valid   = 1;
                m_frame   = m_selpoll ? 8'h03 : {3'b000, m_sel, 2'b10};
                if (!m_selpoll) clr[m_sel] = 1'b1;
            end
            if (give) begin
                m_loading = 1;
                m_selpoll = 1;
                m_sel     = 0;
                for (int i = 7; i >= 0; i--) begin
                    if (m_pend[i]) begin
                        m_sel     = 3'(i);
                        m_selpoll = 0;
                    end
                end
            end
            m_pend = (m_pend | rise | rep_set) & ~clr;
        end
    end

    // Compare every cycle against the model and log each frame handed to the UART.
    always @(negedge uart_clk) begin
        if (chk_en) begin
            check("outputs", 32'({data_send, send_valid, busy, cmd_leds}),
                  32'({m_frame, m_valid, (m_loading || m_valid || (m_gap > 0)), m_leds}));
            if (send_valid && tx_ready && !rst) begin
                dlog.push_back(data_send);
                dcyc.push_back(cyc);
            end
        end
    end

    initial begin
        int         n, cnt, b;
        logic [7:0] d0;
        bit         stable;

        rst = 1'b1; op_req = 8'h00; enable = 1'b1; tx_ready = 1'b1;
        step(1);
        chk_en = 1'b1;
        step(2);
        check("reset_outputs", 32'({data_send, send_valid, busy, cmd_leds}), 32'h0);
        rst = 1'b0;
        step(2);

        // Single GET press: two-edge latency, one-cycle valid, LEDs, gap length.
        op_req = 8'h10;
        wait_valid(10, n);
        check("get_latency", 32'(n), 32'd3);
        check("get_frame", 32'(data_send), 32'h12);
        step(1);
        check("get_valid_one_cycle", 32'(send_valid), 32'd0);
        check("get_leds", 32'(cmd_leds), 32'hC);
        op_req = 8'h00;
        step(GAP - 1);
        check("gap_busy_last", 32'(busy), 32'd1);
        step(1);
        check("gap_done_idle", 32'(busy), 32'd0);

        // Two simultaneous rises are served in index order, separated by the gap.
        dlog.delete(); dcyc.delete();
        op_req = 8'h05;
        step(1);
        op_req = 8'h00;
        step(120);
        check("pair_count", 32'(dlog.size()), 32'd2);
        check("pair_first", 32'(logat(0)), 32'h02);
        check("pair_second", 32'(logat(1)), 32'h0A);
        check("pair_spacing", 32'((cycat(1) - cycat(0)) > GAP), 32'd1);

        // Held LEFT repeats every REP cycles; after release only polls appear.
        dlog.delete(); dcyc.delete();
        op_req = 8'h04;
        step(350);
        cnt = 0;
        foreach (dlog[i]) if (dlog[i] == 8'h0A) cnt++;
        check("hold_repeat_frames", 32'(cnt), 32'd4);
        check("hold_total_frames", 32'(dlog.size()), 32'd4);
        op_req = 8'h00;
        dlog.delete(); dcyc.delete();
        step(400);
        cnt = 0;
        foreach (dlog[i]) if (dlog[i] != 8'h03) cnt++;
        check("release_no_ops", 32'(cnt), 32'd0);
        check("release_poll_seen", 32'(dlog.size() >= 1), 32'd1);
        check("poll_leds", 32'(cmd_leds), 32'h0);

        // Disabled: nothing is sent, but a press still collects and goes out on re-enable.
        enable = 1'b0;
        dlog.delete(); dcyc.delete();
        step(700);
        check("disabled_no_poll", 32'(dlog.size()), 32'd0);
        op_req = 8'h02;
        step(1);
        op_req = 8'h00;
        step(20);
        check("disabled_no_frame", 32'(dlog.size()), 32'd0);
        enable = 1'b1;
        wait_valid(10, n);
        check("resume_frame", 32'(data_send), 32'h06);
        step(1);
        check("resume_leds", 32'(cmd_leds), 32'h9);

        // Stall in SEND for 50 cycles with a second press arriving meanwhile.
        wait_idle(40);
        tx_ready = 1'b0;
        dlog.delete(); dcyc.delete();
        op_req = 8'h08;
        wait_valid(10, n);
        d0 = data_send;
        check("stall_frame", 32'(d0), 32'h0E);
        op_req = 8'h00;
        stable = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (i == 10) op_req = 8'h20;
            if (i == 11) op_req = 8'h00;
            step(1);
            if (!send_valid || data_send != d0) stable = 1'b0;
        end
        check("stall_stable", 32'(stable), 32'd1);
        tx_ready = 1'b1;
        step(80);
        check("stall_count", 32'(dlog.size()), 32'd2);
        check("stall_first", 32'(logat(0)), 32'h0E);
        check("stall_second", 32'(logat(1)), 32'h16);

        // Reset while a frame is presented drops it and any other pending press.
        wait_idle(40);
        tx_ready = 1'b0;
        op_req = 8'h40;
        wait_valid(10, n);
        check("rst_pre_frame", 32'(data_send), 32'h1A);
        op_req = 8'h00;
        step(2);
        op_req = 8'h80;
        step(1);
        op_req = 8'h00;
        rst = 1'b1;
        step(1);
        check("rst_mid_send", 32'({data_send, send_valid, busy, cmd_leds}), 32'h0);
        rst = 1'b0;
        tx_ready = 1'b1;
        dlog.delete(); dcyc.delete();
        step(100);
        check("rst_no_frame", 32'(dlog.size()), 32'd0);

        // Randomized traffic, enable, backpressure and occasional reset.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                b = $urandom_range(0, 7);
                op_req[b] = ~op_req[b];
            end
            enable   = ($urandom_range(0, 19) != 0);
            tx_ready = ($urandom_range(0, 9) < 7);
            rst      = ($urandom_range(0, 599) == 0);
            step(1);
        end
        rst = 1'b0;
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, bad_cnt);
        $finish;
    end

endmodule
